// File: rtl/run_stream_serializer.sv
// run_stream_serializer: turns WIDTH-bit words into a one-bit-per-clock stream for the run detector
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_data    word to serialize
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle
//   x          registered serial bit, holds its value between words
//   x_valid    x carries a bit of a word this cycle
//   word_done  pulse while the last bit of a word is on x
//   busy       a word is shifting or pending
module run_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [WIDTH-1:0] sreg, pbuf;
    logic [CW-1:0] cnt;
    logic pvalid, load, accept, at_last;
    assign at_last   = cnt == LAST;
    assign load      = pvalid && (state == IDLE || at_last);
    assign in_ready  = !pvalid || load;
    assign accept    = in_valid && in_ready;
    assign word_done = x_valid && at_last;
    assign busy      = state == SHIFT || pvalid;
    // sreg shifts toward the outgoing end so the next bit always sits at a fixed index
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pvalid  <= 1'b0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            if (accept) begin
                pbuf   <= in_data;
                pvalid <= 1'b1;
            end else if (load) begin
                pvalid <= 1'b0;
            end
            if (load) begin
                sreg    <= pbuf;
                x       <= MSB_FIRST ? pbuf[WIDTH-1] : pbuf[0];
                cnt     <= '0;
                x_valid <= 1'b1;
                state   <= SHIFT;
            end else if (state == SHIFT) begin
                if (at_last) begin
                    state   <= IDLE;
                    x_valid <= 1'b0;
                end else begin
                    cnt  <= cnt + 1'b1;
                    x    <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
                    sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
                end
            end
        end
    end
endmodule

// File: doc/run_stream_serializer.md
# run_stream_serializer

Parallel-to-serial front end for the run-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`, which drives the detector's serial input directly. A one-entry pending buffer lets back-to-back words stream with no idle gap. `x` holds its last value between words, so the downstream detector never sees spurious bit transitions.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-low: the block resets on a clk edge where rst=0.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block can accept a word this cycle.
- x  output  1  serial bit, registered; feeds the detector's `x`.
- x_valid  output  1  `x` carries a bit of a word this cycle.
- word_done  output  1  one-cycle pulse while the last bit of a word is on `x`.
- busy  output  1  a word is being shifted or is pending.

## Operation
- State: FSM {IDLE, SHIFT}; shift register `sreg[WIDTH-1:0]`; bit counter `cnt` of width $clog2(WIDTH); pending buffer `pbuf` plus flag `pvalid`.
- Reset (rst=0 at an edge):
  - state=IDLE, pvalid=0, cnt=0, x=0, x_valid=0, word_done=0.
  - in_data and in_valid are ignored on that edge.
- `load` = pvalid && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
- in_ready = !pvalid || load. It depends on registered state only and has no combinational path from in_valid.
- Accept: at a rising edge with in_valid && in_ready, pbuf<=in_data and pvalid<=1. pvalid stays 1 when load and accept occur on the same edge.
- When load fires at an edge:
  - pvalid<=0, unless a simultaneous accept occurs.
  - x<=first bit of pbuf; sreg<=pbuf; cnt<=0; x_valid<=1; state<=SHIFT.
- SHIFT with cnt<WIDTH-1: cnt<=cnt+1 and x<=next bit (MSB_FIRST: bit WIDTH-2-cnt; else bit cnt+1).
- SHIFT with cnt==WIDTH-1 and no load: state<=IDLE, x_valid<=0, x holds its value.
- word_done = x_valid && cnt==WIDTH-1. This is a registered-state decode.
- busy = (state==SHIFT) || pvalid.
- x does not change while x_valid=0, except on reset, which forces x=0.
- Words are never dropped or reordered, and each word produces exactly WIDTH valid bits.

## Timing
- Latency:
  - Word accepted at edge N while idle and empty: pvalid=1 after N.
  - First bit on x after edge N+1.
  - Last bit on x after edge N+WIDTH, with word_done high in that cycle.
- Throughput: one word per WIDTH cycles. With pbuf refilled before each last bit, x_valid stays high continuously.
- Backpressure: after the pending buffer fills during SHIFT, in_ready stays low until the edge at which the current word's last bit leaves (load cycle).
- Reset mid-word: the partial word and any pending word are discarded. x=0 and x_valid=0 from the reset edge; there is no resumption.
- Counter: cnt never exceeds WIDTH-1. There is no wrap beyond that; the reload happens on the load edge.

## Test plan
- Single word (WIDTH=8, MSB_FIRST=1), 8'hE3 at edge N → x=1,1,1,0,0,0,1,1 on cycles N+1..N+8; x_valid high for exactly those 8 cycles; word_done only at N+8; x stays 1 afterwards with x_valid=0.
- Back-to-back 8'hFF then 8'h00 with in_valid held high → 16 consecutive x_valid cycles; x=eight 1s then eight 0s; word_done at cycles 8 and 16; in_ready low from the second accept until the first load edge.
- Backpressure: in_valid held high with 8'hA5, 8'h5A, 8'h3C queued → each word accepted only when in_ready=1; output bit stream matches the three words in order; no word lost or duplicated.
- LSB-first (MSB_FIRST=0), 8'h01 → x=1,0,0,0,0,0,0,0.
- Reset mid-word: rst=0 at bit 4 of 8'hF0 with 8'h0F pending → x=0, x_valid=0, busy=0, in_ready=1 next cycle; no further bits from either word; a new 8'h81 then serializes normally.
- Idle stability: 20 cycles of in_valid=0 after 8'h01 (MSB-first) → x holds 1 throughout and x_valid=0; the downstream detector sees no transitions.
